// File: rtl/llc_plru_engine_if.sv
// Request/response bundle between the LLC controller and the tree-PLRU engine.
// The controller holds the master side and the engine holds the slave side.
interface llc_plru_engine_if #(
   parameter int ASSOCIATIVITY = 16,
   parameter int NUM_SETS      = 16384
);
   localparam int WAY_W = $clog2(ASSOCIATIVITY);
   localparam int SET_W = $clog2(NUM_SETS);

   logic                     busy;
   logic                     req_valid;
   logic                     req_ready;
   logic [1:0]               req_op;
   logic [SET_W-1:0]         req_set;
   logic [WAY_W-1:0]         req_way;
   logic [ASSOCIATIVITY-1:0] req_valid_mask;
   logic                     rsp_valid;
   logic [WAY_W-1:0]         rsp_way;
   logic                     rsp_from_invalid;

   modport master (
      output req_valid, req_op, req_set, req_way, req_valid_mask,
      input  busy, req_ready, rsp_valid, rsp_way, rsp_from_invalid
   );

   modport slave (
      input  req_valid, req_op, req_set, req_way, req_valid_mask,
      output busy, req_ready, rsp_valid, rsp_way, rsp_from_invalid
   );
endinterface

// File: rtl/llc_plru_engine.sv
// Tree pseudo-LRU replacement engine: per-set PLRU bits in a synchronous array,
// 2-stage pipeline (read, then compute + write-back) with same-set forwarding.
//
// state    | meaning
// ST_RUN   | accepting requests
// ST_SWEEP | zeroing one set per cycle after reset, requests held off
module llc_plru_engine #(
   parameter int ASSOCIATIVITY = 16,
   parameter int NUM_SETS      = 16384,
   parameter bit INIT_ON_RESET = 1'b1
) (
   input  logic                clk,
   input  logic                rst,
   llc_plru_engine_if.slave    bus
);
   localparam int WAY_W = $clog2(ASSOCIATIVITY);
   localparam int SET_W = $clog2(NUM_SETS);
   localparam int P_LRU = ASSOCIATIVITY - 1;

   typedef enum logic [1:0] {OP_TOUCH = 2'd0, OP_VICTIM = 2'd1, OP_QUERY = 2'd2, OP_CLEAR = 2'd3} op_e;
   typedef enum logic {ST_RUN = 1'b0, ST_SWEEP = 1'b1} state_e;

   logic [P_LRU-1:0]         plru_mem [NUM_SETS];

   state_e                   state_q, state_d;
   logic [SET_W-1:0]         sweep_cnt;
   logic                     sweep_we;
   logic                     accept;

   logic                     s1_valid;
   op_e                      s1_op;
   logic [SET_W-1:0]         s1_set;
   logic [WAY_W-1:0]         s1_way;
   logic [ASSOCIATIVITY-1:0] s1_mask;
   logic [P_LRU-1:0]         rd_bits;

   logic                     wb_valid;
   logic [SET_W-1:0]         wb_set;
   logic [P_LRU-1:0]         wb_bits;

   logic [P_LRU-1:0]         cur_bits, touched, nxt_bits;
   logic [WAY_W-1:0]         walk_way, inv_way, sel_way, inv_cnt, way_sh;
   logic [WAY_W-1:0]         node_w, node_t;
   logic [ASSOCIATIVITY-1:0] mask_sh;
   logic                     dir, inv_hit, from_inv, wr_en;

   assign bus.busy      = (state_q == ST_SWEEP);
   assign bus.req_ready = ~bus.busy;
   assign accept        = bus.req_valid & bus.req_ready;

   always_ff @(posedge clk) begin
      if (rst) state_q <= INIT_ON_RESET ? ST_SWEEP : ST_RUN;
      else     state_q <= state_d;
   end

   always_comb begin
      state_d  = state_q;
      sweep_we = 1'b0;
      case (state_q)
         ST_SWEEP: begin
            sweep_we = 1'b1;
            if (sweep_cnt == SET_W'(NUM_SETS - 1)) state_d = ST_RUN;
         end
         default: ;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst)           sweep_cnt <= '0;
      else if (sweep_we) sweep_cnt <= sweep_cnt + SET_W'(1);
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         s1_valid         <= 1'b0;
         wb_valid         <= 1'b0;
         bus.rsp_valid    <= 1'b0;
         bus.rsp_way      <= '0;
         bus.rsp_from_invalid <= 1'b0;
      end else begin
         s1_valid      <= accept;
         wb_valid      <= wr_en;
         bus.rsp_valid <= s1_valid;
         if (s1_valid) begin
            bus.rsp_way          <= sel_way;
            bus.rsp_from_invalid <= from_inv;
         end
      end
   end

   always_ff @(posedge clk) begin
      if (accept) begin
         s1_op   <= op_e'(bus.req_op);
         s1_set  <= bus.req_set;
         s1_way  <= bus.req_way;
         s1_mask <= bus.req_valid_mask;
      end
      wb_set  <= s1_set;
      wb_bits <= nxt_bits;
   end

   // Sweep and request write-back never overlap: requests are held off while sweeping.
   always_ff @(posedge clk) begin
      if (sweep_we && !rst) plru_mem[sweep_cnt] <= '0;
      else if (wr_en)       plru_mem[s1_set]    <= nxt_bits;
      if (accept) rd_bits <= plru_mem[bus.req_set];
   end

   assign wr_en = s1_valid & (s1_op != OP_QUERY) & ~rst;

   always_comb begin
      cur_bits = (wb_valid && wb_set == s1_set) ? wb_bits : rd_bits;

      walk_way = '0;
      node_w   = '0;
      dir      = 1'b0;
      for (int l = 0; l < WAY_W; l++) begin
         dir      = cur_bits[node_w];
         walk_way = (walk_way << 1) | WAY_W'(dir);
         node_w   = (node_w << 1) + WAY_W'(1) + WAY_W'(dir);
      end

      inv_way = '0;
      inv_hit = 1'b0;
      inv_cnt = '0;
      mask_sh = s1_mask;
      for (int i = 0; i < ASSOCIATIVITY; i++) begin
         if (!inv_hit && !mask_sh[0]) begin
            inv_way = inv_cnt;
            inv_hit = 1'b1;
         end
         mask_sh = mask_sh >> 1;
         inv_cnt = inv_cnt + WAY_W'(1);
      end

      from_inv = inv_hit && (s1_op == OP_VICTIM || s1_op == OP_QUERY);
      case (s1_op)
         OP_TOUCH: sel_way = s1_way;
         OP_CLEAR: sel_way = '0;
         default:  sel_way = inv_hit ? inv_way : walk_way;
      endcase

      // Each node on the path is pointed at the half that does not hold sel_way.
      touched = cur_bits;
      node_t  = '0;
      way_sh  = sel_way;
      for (int l = 0; l < WAY_W; l++) begin
         touched[node_t] = ~way_sh[WAY_W-1];
         node_t = (node_t << 1) + WAY_W'(1) + WAY_W'(way_sh[WAY_W-1]);
         way_sh = way_sh << 1;
      end

      nxt_bits = (s1_op == OP_CLEAR) ? '0 : touched;
   end
endmodule

// File: tb/tb_llc_plru_engine.sv
// Bench for llc_plru_engine (16 ways, 16 sets): directed scenarios plus random
// traffic scored against an interval-halving PLRU model.
module tb_llc_plru_engine;
   localparam int ASSOC = 16;
   localparam int SETS  = 16;
   localparam int NODES = ASSOC - 1;

   logic clk = 1'b0;
   logic rst = 1'b1;
   int   cyc = 0;
   int   n_chk = 0;
   int   n_fail = 0;

   llc_plru_engine_if #(.ASSOCIATIVITY(ASSOC), .NUM_SETS(SETS)) bus ();

   llc_plru_engine #(.ASSOCIATIVITY(ASSOC), .NUM_SETS(SETS), .INIT_ON_RESET(1'b1)) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   typedef struct {
      int way;
      int inv;
      int due;
   } exp_t;

   exp_t q[$];
   exp_t e_mon;
   bit   tr [SETS][NODES];

   task automatic check(input string tag, input int obs, input int exp);
      n_chk++;
      if (obs != exp) begin
         n_fail++;
         $display("FAIL %s: got %0d, expected %0d (cycle %0d)", tag, obs, exp, cyc);
      end
   endtask

   // Model walks by halving the way range; a set bit means "victim lies in the upper half".
   function automatic int mdl_walk(input int s);
      int lo = 0, size = ASSOC, node = 0;
      while (size > 1) begin
         size = size / 2;
         if (tr[s][node]) begin
            lo   = lo + size;
            node = 2 * node + 2;
         end else begin
            node = 2 * node + 1;
         end
      end
      return lo;
   endfunction

   task automatic mdl_touch(input int s, input int w);
      int lo = 0, size = ASSOC, node = 0;
      while (size > 1) begin
         size = size / 2;
         if (w < lo + size) begin
            tr[s][node] = 1'b1;
            node = 2 * node + 1;
         end else begin
            tr[s][node] = 1'b0;
            lo   = lo + size;
            node = 2 * node + 2;
         end
      end
   endtask

   task automatic mdl_reset();
      for (int s = 0; s < SETS; s++)
         for (int n = 0; n < NODES; n++) tr[s][n] = 1'b0;
   endtask

   task automatic mdl_select(input int s, input logic [ASSOC-1:0] mask, output int w, output int inv);
      w   = -1;
      inv = 0;
      for (int i = 0; i < ASSOC; i++)
         if (w < 0 && mask[i] == 1'b0) w = i;
      if (w >= 0) inv = 1;
      else        w = mdl_walk(s);
   endtask

   task automatic issue(input int op, input int set, input int way, input logic [ASSOC-1:0] mask,
                        input bit use_c, input int c_way, input int c_inv);
      exp_t e;
      int   w, inv;
      @(negedge clk);
      bus.req_valid      = 1'b1;
      bus.req_op         = 2'(op);
      bus.req_set        = 4'(set);
      bus.req_way        = 4'(way);
      bus.req_valid_mask = mask;
      if (!bus.req_ready) check("req_ready", int'(bus.req_ready), 1);
      else begin
         w = 0; inv = 0;
         case (op)
            0: begin w = way; mdl_touch(set, way); end
            1: begin mdl_select(set, mask, w, inv); mdl_touch(set, w); end
            2: mdl_select(set, mask, w, inv);
            default: for (int n = 0; n < NODES; n++) tr[set][n] = 1'b0;
         endcase
         e.way = use_c ? c_way : w;
         e.inv = use_c ? c_inv : inv;
         e.due = cyc + 2;
         q.push_back(e);
      end
      @(posedge clk);
      #1 bus.req_valid = 1'b0;
   endtask

   task automatic count_busy(input int limit, output int n);
      n = 0;
      while (bus.busy && n < limit) begin
         n++;
         @(negedge clk);
      end
   endtask

   always @(negedge clk) begin
      if (bus.rsp_valid) begin
         if (q.size() == 0) check("unexpected_rsp", int'(bus.rsp_valid), 0);
         else begin
            e_mon = q.pop_front();
            check("rsp_way", int'(bus.rsp_way), e_mon.way);
            check("rsp_from_invalid", int'(bus.rsp_from_invalid), e_mon.inv);
            check("rsp_latency", cyc, e_mon.due);
         end
      end else if (q.size() > 0 && q[0].due < cyc) begin
         check("rsp_missing", int'(bus.rsp_valid), 1);
         void'(q.pop_front());
      end
   end

   initial begin
      #2_000_000;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1);
   end

   initial begin
      int n;
      logic [ASSOC-1:0] m;
      bus.req_valid      = 1'b0;
      bus.req_op         = '0;
      bus.req_set        = '0;
      bus.req_way        = '0;
      bus.req_valid_mask = '1;
      mdl_reset();

      repeat (3) @(negedge clk);
      check("rst_busy", int'(bus.busy), 1);
      check("rst_ready", int'(bus.req_ready), 0);
      check("rst_rsp_valid", int'(bus.rsp_valid), 0);
      check("rst_rsp_way", int'(bus.rsp_way), 0);
      check("rst_rsp_inv", int'(bus.rsp_from_invalid), 0);

      rst = 1'b0;
      check("sweep_ready", int'(bus.req_ready), 0);
      count_busy(100, n);
      check("sweep_cycles", n, SETS);

      issue(2, 3, 0, 16'hFFFF, 1, 0, 0);
      issue(0, 5, 0, 16'hFFFF, 1, 0, 0);
      issue(2, 5, 0, 16'hFFFF, 1, 8, 0);
      issue(0, 5, 8, 16'hFFFF, 1, 8, 0);
      issue(2, 5, 0, 16'hFFFF, 1, 4, 0);
      issue(1, 7, 0, 16'hFFFF, 1, 0, 0);
      issue(1, 7, 0, 16'hFFFF, 1, 8, 0);
      issue(1, 7, 0, 16'hFFFF, 1, 4, 0);
      issue(1, 1, 0, 16'hFFF7, 1, 3, 1);
      issue(2, 1, 0, 16'hFFFF, 1, 8, 0);
      issue(1, 2, 0, 16'hFFFF, 1, 0, 0);
      issue(1, 2, 0, 16'hFFFF, 1, 8, 0);
      issue(3, 2, 0, 16'hFFFF, 1, 0, 0);
      issue(2, 2, 0, 16'hFFFF, 1, 0, 0);

      for (int i = 0; i < 400; i++) begin
         m = ($urandom_range(0, 3) == 0) ? 16'($urandom) : 16'hFFFF;
         issue($urandom_range(0, 3),
               ($urandom_range(0, 1) == 1) ? $urandom_range(0, 3) : $urandom_range(0, SETS - 1),
               $urandom_range(0, ASSOC - 1), m, 0, 0, 0);
         if ($urandom_range(0, 4) == 0) @(negedge clk);
      end
      repeat (6) @(negedge clk);
      check("drain_random", q.size(), 0);

      @(negedge clk);
      bus.req_valid      = 1'b1;
      bus.req_op         = 2'd1;
      bus.req_set        = 4'd4;
      bus.req_valid_mask = 16'hFFFF;
      @(posedge clk);
      #1 bus.req_valid = 1'b0;
      @(negedge clk);
      rst = 1'b1;
      @(negedge clk);
      check("flush_rsp_valid", int'(bus.rsp_valid), 0);
      rst = 1'b0;
      count_busy(9, n);
      check("partial_sweep", n, 9);
      rst = 1'b1;
      @(negedge clk);
      check("rerst_busy", int'(bus.busy), 1);
      rst = 1'b0;
      count_busy(100, n);
      check("resweep_cycles", n, SETS);
      mdl_reset();

      issue(2, 4, 0, 16'hFFFF, 1, 0, 0);
      issue(1, 4, 0, 16'hFFFF, 1, 0, 0);
      issue(2, 4, 0, 16'hFFFF, 1, 8, 0);
      repeat (6) @(negedge clk);
      check("drain_final", q.size(), 0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end
endmodule
